mram_port_arbiter: RTL

MRAM_PORT_ARBITER -- requirements
Module: mram_port_arbiter

---
 rtl/mram_port_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mram_port_arbiter.sv
// mram_port_arbiter: shares MRAM port A among three requesters (pooling writer,
// conv writer, host/DMA). Round-robin grant, per-grant burst limit while others
// wait, registered port-A drive and a two-stage read-return pipeline.
module mram_port_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          req,
  input  logic [3*ADDR_W-1:0] addr_flat,
  input  logic [3*DATA_W-1:0] din_flat,
  input  logic [11:0]         we_flat,
  output logic [2:0]          gnt,
  output logic [2:0]          rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic [ADDR_W-1:0]   mram_addr_a,
  output logic [DATA_W-1:0]   mram_din_a,
  output logic                mram_en_a,
  output logic [3:0]          mram_we_a,
  input  logic [DATA_W-1:0]   mram_dout
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nxt;
  logic [2:0]        gnt_nxt;
  logic [1:0]        last_owner, last_owner_nxt;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
  logic [1:0]        rr_winner;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_din;
  logic [3:0]        own_we;
  logic              accept;
  logic              others_waiting;
  logic [2:0]        rd_pend;

  // Round-robin pick: search begins at the requester after the last owner.
  always_comb begin
    rr_winner = 2'd0;
    case (last_owner)
      2'd0:    rr_winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    rr_winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: rr_winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Select the current owner's address, data and byte enables.
  always_comb begin
    own_addr = addr_flat[0 +: ADDR_W];
    own_din  = din_flat[0 +: DATA_W];
    own_we   = we_flat[3:0];
    case (last_owner)
      2'd1: begin
        own_addr = addr_flat[ADDR_W +: ADDR_W];
        own_din  = din_flat[DATA_W +: DATA_W];
        own_we   = we_flat[7:4];
      end
      2'd2: begin
        own_addr = addr_flat[2*ADDR_W +: ADDR_W];
        own_din  = din_flat[2*DATA_W +: DATA_W];
        own_we   = we_flat[11:8];
      end
      default: begin
      end
    endcase
  end

  // gnt is one-hot on the owner, so any overlap with req is an accepted beat.
  assign accept         = (state == GRANT) && |(req & gnt);
  assign others_waiting = |(req & ~gnt);

  // Arbitration state register; last_owner starts at 2 so requester 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= 3'b000;
      last_owner <= 2'd2;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  // Next-state: grant from IDLE, release on req drop or on a full burst with waiters.
  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    last_owner_nxt = last_owner;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        gnt_nxt = 3'b000;
        if (|req) begin
          state_nxt      = GRANT;
          gnt_nxt        = 3'b001 << rr_winner;
          last_owner_nxt = rr_winner;
          beat_cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (!accept) begin
          state_nxt = IDLE;
          gnt_nxt   = 3'b000;
        end else if (beat_cnt == LAST_BEAT) begin
          beat_cnt_nxt = '0;
          if (others_waiting) begin
            state_nxt = IDLE;
            gnt_nxt   = 3'b000;
          end
        end else begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 3'b000;
      end
    endcase
  end

  // Port A drive: one cycle after an accepted beat; address and data hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mram_en_a   <= 1'b0;
      mram_we_a   <= 4'b0000;
      mram_addr_a <= '0;
      mram_din_a  <= '0;
    end else begin
      mram_en_a <= accept;
      if (accept) begin
        mram_addr_a <= own_addr;
        mram_din_a  <= own_din;
        mram_we_a   <= own_we;
      end else begin
        mram_we_a <= 4'b0000;
      end
    end
  end

  // Read return: rd_pend tracks the enable cycle of a read, and mram_dout is
  // captured at the close of that cycle so rd_data and rd_valid land together
  // two cycles after acceptance, regardless of what happens to gnt meanwhile.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend  <= 3'b000;
      rd_valid <= 3'b000;
      rd_data  <= '0;
    end else begin
      rd_pend  <= (accept && (own_we == 4'b0000)) ? gnt : 3'b000;
      rd_valid <= rd_pend;
      if (|rd_pend) begin
        rd_data <= mram_dout;
      end
    end
  end

endmodule
